instr_fetch_unit: RTL

//  Fetch stage directly upstream of InstructionMemory: owns the PC, drives the 6-bit word address, captures rd.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 75 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    // Value driven on out_instr while nothing is valid
    localparam logic [INSTR_W-1:0] NOP   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Byte PCs are always word aligned; low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular buffer holding fetched {pc, instr} pairs for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head_data,
    output logic         empty,
    output logic         full
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // A push into a full queue is only legal when the head leaves the same cycle
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_FULL);
    assign head_data = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; flush and reset both empty the queue
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads InstructionMemory, queues results for decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2,
    parameter int          ADDR_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        fetch_cnt
);

    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_cnt;

    fetch_entry_t w_push_data;
    fetch_entry_t w_head;
    logic         w_empty;
    logic         w_full;
    logic         w_transfer;
    logic         w_enq;

    assign imem_addr   = r_pc[ADDR_W+1:2];
    assign w_push_data = '{pc: r_pc, instr: imem_rd};

    // Valid comes purely from queue state, never from out_ready
    assign out_valid   = !w_empty;
    assign w_transfer  = out_valid && out_ready;
    // Redirect suppresses the enqueue; a full queue accepts only if the head leaves
    assign w_enq       = !redirect_valid && (!w_full || w_transfer);

    assign out_instr   = out_valid ? w_head.instr : NOP;
    assign out_pc      = out_valid ? w_head.pc    : 32'h0000_0000;
    assign fetch_cnt   = r_fetch_cnt;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (w_enq),
        .push_data (w_push_data),
        .pop       (w_transfer),
        .head_data (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    // PC update: redirect wins, otherwise advance on every enqueue
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_pc <= RESET_PC;
        else if (redirect_valid)
            r_pc <= align_pc(redirect_pc);
        else if (w_enq)
            r_pc <= r_pc + 32'd4;
    end

    // Count handshakes to decode, including one coinciding with a redirect
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_fetch_cnt <= 32'd0;
        else if (w_transfer)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end

endmodule
